// File: rtl/mdu_iterative_pkg.sv
// mdu_iterative_pkg
// Shared constants and types for the iterative RV32M multiply/divide unit:
// M-extension decode constants, func3 encodings, MDU FSM state encoding and
// small helpers that classify operand signedness per func3.
package mdu_iterative_pkg;

   localparam int F3_W = 3;

   localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;
   localparam logic [6:0] FUNC7_MEXT   = 7'b0000001;

   localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
   localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
   localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
   localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
   localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
   localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
   localparam logic [F3_W-1:0] F3_REM    = 3'b110;
   localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } mdu_state_t;

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM
   function automatic logic signedA(input logic [F3_W-1:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM only
   function automatic logic signedB(input logic [F3_W-1:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/mdu_iterative_if.sv
// mdu_iterative_if
// Handshake bundle between the execute stage (master) and the MDU (slave).
//   start/func3/op_a/op_b : request and operands, sampled on acceptance
//   flush                 : abort any in-flight operation
//   busy/result_valid     : unit occupied / one-cycle completion pulse
//   result                : registered result, held until next acceptance
interface mdu_iterative_if
   import mdu_iterative_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   logic [F3_W-1:0] func3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            flush;
   logic            busy;
   logic            result_valid;
   logic [XLEN-1:0] result;

   modport master (
      output start, func3, op_a, op_b, flush,
      input  busy, result_valid, result
   );

   modport slave (
      input  start, func3, op_a, op_b, flush,
      output busy, result_valid, result
   );
endinterface

// File: rtl/mdu_iterative_sign_fix.sv
// mdu_sign_fix
// Combinational conditional two's-complement negate, used both to take
// operand magnitudes and to restore the sign of the final result.
//   i_neg : negate when high
//   i_val : W-bit value
//   o_val : i_val or -i_val (modulo 2^W)
module mdu_sign_fix #(
   parameter int W = 32
) (
   input  logic         i_neg,
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);
   assign o_val = i_neg ? (~i_val + W'(1)) : i_val;
endmodule

// File: rtl/mdu_iterative.sv
// mdu_iterative
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle:
// shift-add multiply into a 2*XLEN product, restoring division with the
// remainder in the upper half and the quotient in the lower half of the
// same register. Divide-by-zero and signed overflow are resolved at
// acceptance and skip straight to DONE.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mdu_iterative_if slave (start/func3/op_a/op_b/flush in,
//         busy/result_valid/result out)
module mdu_iterative
   import mdu_iterative_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst,
   mdu_iterative_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;

   mdu_state_t        r_state;
   mdu_state_t        w_nextState;
   logic [CNT_W-1:0]  r_cnt;
   logic [F3_W-1:0]   r_func3;
   logic              r_neg;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic [XLEN-1:0]   r_result;
   logic [2*XLEN-1:0] r_prod;

   logic              w_accept;
   logic              w_divZero;
   logic              w_overflow;
   logic              w_special;
   logic [XLEN-1:0]   w_specialRes;
   logic              w_negA;
   logic              w_negB;
   logic              w_resNeg;
   logic [XLEN-1:0]   w_absA;
   logic [XLEN-1:0]   w_absB;
   logic [XLEN:0]     w_mulSum;
   logic [XLEN:0]     w_divShift;
   logic [XLEN:0]     w_divDiff;
   logic [2*XLEN-1:0] w_stepNext;
   logic [2*XLEN-1:0] w_prodFix;
   logic [XLEN-1:0]   w_divSel;
   logic [XLEN-1:0]   w_divFix;
   logic [XLEN-1:0]   w_fixRes;

   // Acceptance decode: a start is only taken in IDLE when no flush is pending
   assign w_accept   = bus.start && !bus.flush && (r_state == S_IDLE);
   assign w_divZero  = bus.func3[2] && (bus.op_b == '0);
   assign w_overflow = ((bus.func3 == F3_DIV) || (bus.func3 == F3_REM)) &&
                       (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
   assign w_special  = w_divZero || w_overflow;

   // func3[1] separates REM* from DIV* within the divide group
   assign w_specialRes = w_divZero ? (bus.func3[1] ? bus.op_a : '1)
                                   : (bus.func3[1] ? '0 : bus.op_a);

   // REM takes the dividend sign; every other signed op takes a^b, which
   // collapses to a alone for MULHSU since b is never negated there
   assign w_negA   = signedA(bus.func3) && bus.op_a[XLEN-1];
   assign w_negB   = signedB(bus.func3) && bus.op_b[XLEN-1];
   assign w_resNeg = (bus.func3 == F3_REM) ? w_negA : (w_negA ^ w_negB);

   mdu_sign_fix #(.W(XLEN)) u_absA (.i_neg(w_negA), .i_val(bus.op_a), .o_val(w_absA));
   mdu_sign_fix #(.W(XLEN)) u_absB (.i_neg(w_negB), .i_val(bus.op_b), .o_val(w_absB));

   // One iteration step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      w_mulSum   = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);
      w_divShift = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
      w_divDiff  = w_divShift - {1'b0, r_b};
      w_stepNext = {w_mulSum, r_prod[XLEN-1:1]};
      if (r_func3[2]) begin
         if (w_divDiff[XLEN]) begin
            w_stepNext = {w_divShift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
         end else begin
            w_stepNext = {w_divDiff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
         end
      end
   end

   // Final sign restoration and half/quotient/remainder selection
   assign w_divSel = r_func3[1] ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];

   mdu_sign_fix #(.W(2*XLEN)) u_prodFix (.i_neg(r_neg), .i_val(r_prod), .o_val(w_prodFix));
   mdu_sign_fix #(.W(XLEN))   u_divFix  (.i_neg(r_neg), .i_val(w_divSel), .o_val(w_divFix));

   always_comb begin
      w_fixRes = w_divFix;
      case (r_func3)
         F3_MUL:                      w_fixRes = w_prodFix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: w_fixRes = w_prodFix[2*XLEN-1:XLEN];
         default:                     w_fixRes = w_divFix;
      endcase
   end

   // Next-state logic; flush wins over everything and returns to IDLE
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_nextState = w_special ? S_DONE : S_RUN;
         S_RUN:  if (r_cnt == CNT_W'(1)) w_nextState = S_FIX;
         S_FIX:  w_nextState = S_DONE;
         S_DONE: w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
      if (bus.flush) w_nextState = S_IDLE;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Datapath: operand capture on acceptance, iteration in RUN, result write
   // in FIX; a flush blocks both the iteration and the result write
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt    <= '0;
         r_func3  <= '0;
         r_neg    <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_prod   <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_func3 <= bus.func3;
         r_neg   <= w_resNeg;
         r_a     <= w_absA;
         r_b     <= w_absB;
         r_prod  <= {{XLEN{1'b0}}, (bus.func3[2] ? w_absA : w_absB)};
         if (w_special) begin
            r_cnt    <= '0;
            r_result <= w_specialRes;
         end else begin
            r_cnt <= CNT_W'(XLEN);
         end
      end else if (!bus.flush) begin
         if (r_state == S_RUN) begin
            r_prod <= w_stepNext;
            r_cnt  <= r_cnt - CNT_W'(1);
         end else if (r_state == S_FIX) begin
            r_result <= w_fixRes;
         end
      end
   end

   assign bus.busy         = (r_state != S_IDLE);
   assign bus.result_valid = (r_state == S_DONE);
   assign bus.result       = r_result;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative
// Directed bench for mdu_iterative (XLEN=32): a table of hand-computed
// vectors covering every func3 and the special cases, followed by
// hand-written sequences for reset, flush, busy-start and mid-op reset.
module tb_mdu_iterative;
   import mdu_iterative_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mdu_iterative_if #(.XLEN(32)) bus ();

   mdu_iterative #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(string n, logic [2:0] f3, logic [31:0] a,
                                  logic [31:0] b, logic [31:0] e, int lat);
      vec_t v;
      v.name = n; v.f3 = f3; v.a = a; v.b = b; v.exp = e; v.lat = lat;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Starting at the negedge after edge k0, wait for result_valid; lat is
   // the edge index after which it was first seen, -1 on timeout
   task automatic waitValid(input int k0, output logic [31:0] res, output int lat,
                            output bit busyHeld);
      lat = -1; res = '0; busyHeld = 1'b1;
      for (int k = k0; k < k0 + 100; k++) begin
         if (!bus.busy) busyHeld = 1'b0;
         if (bus.result_valid) begin
            lat = k; res = bus.result;
            break;
         end
         @(negedge clk);
         bus.op_a = $urandom;
         bus.op_b = $urandom;
      end
   endtask

   // Present one request, accept it at edge 0, drop start at the negedge after
   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = f3; bus.op_a = a; bus.op_b = b;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.func3 = $urandom_range(0, 7);
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
   endtask

   initial begin
      logic [31:0] res;
      int          lat;
      bit          busyHeld;
      int          seen;

      vecs.push_back(mkVec("MUL 7*-3",        F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33));
      vecs.push_back(mkVec("MUL shift",       F3_MUL,    32'h12345678, 32'h10,       32'h23456780, 33));
      vecs.push_back(mkVec("MULH min*min",    F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33));
      vecs.push_back(mkVec("MULH -3*5",       F3_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33));
      vecs.push_back(mkVec("MULHU max*max",   F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33));
      vecs.push_back(mkVec("MULHU 2^31*4",    F3_MULHU,  32'h80000000, 32'd4,        32'd2,        33));
      vecs.push_back(mkVec("MULHSU -1*max",   F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33));
      vecs.push_back(mkVec("MULHSU min*2",    F3_MULHSU, 32'h80000000, 32'd2,        32'hFFFFFFFF, 33));
      vecs.push_back(mkVec("DIV -7/2",        F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33));
      vecs.push_back(mkVec("REM -7%2",        F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33));
      vecs.push_back(mkVec("DIV 7/-2",        F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33));
      vecs.push_back(mkVec("REM 7%-2",        F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33));
      vecs.push_back(mkVec("DIV -8/-3",       F3_DIV,    32'hFFFFFFF8, 32'hFFFFFFFD, 32'd2,        33));
      vecs.push_back(mkVec("REM -8%-3",       F3_REM,    32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 33));
      vecs.push_back(mkVec("DIVU 100/7",      F3_DIVU,   32'd100,      32'd7,        32'd14,       33));
      vecs.push_back(mkVec("REMU 100%7",      F3_REMU,   32'd100,      32'd7,        32'd2,        33));
      vecs.push_back(mkVec("DIVU max/1",      F3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33));
      vecs.push_back(mkVec("REMU 3%16",       F3_REMU,   32'd3,        32'h10,       32'd3,        33));
      vecs.push_back(mkVec("DIVU 5/0",        F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0));
      vecs.push_back(mkVec("REM 5%0",         F3_REM,    32'd5,        32'd0,        32'd5,        0));
      vecs.push_back(mkVec("DIV ovf",         F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0));
      vecs.push_back(mkVec("REM ovf",         F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0));

      bus.start = 1'b0; bus.flush = 1'b0; bus.func3 = '0; bus.op_a = '0; bus.op_b = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset busy",   32'(bus.busy), 32'd0);
      checkOutput("reset valid",  32'(bus.result_valid), 32'd0);
      checkOutput("reset result", bus.result, 32'd0);
      rst = 1'b1;

      // Table-driven vectors
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].f3, vecs[i].a, vecs[i].b);
         waitValid(0, res, lat, busyHeld);
         checkOutput({vecs[i].name, " result"}, res, vecs[i].exp);
         checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
         checkOutput({vecs[i].name, " busy held"}, 32'(busyHeld), 32'd1);
         @(negedge clk);
         checkOutput({vecs[i].name, " pulse end"}, {30'd0, bus.busy, bus.result_valid}, 32'd0);
      end

      // start pulsed at edge 5 of a running DIVU is ignored
      applyStimulus(F3_DIVU, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.func3 = F3_MUL; bus.op_a = 32'd3; bus.op_b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      waitValid(5, res, lat, busyHeld);
      checkOutput("busy start result", res, 32'd14);
      checkOutput("busy start latency", 32'(lat), 32'd33);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.busy || bus.result_valid) seen++;
      end
      checkOutput("busy start not queued", 32'(seen), 32'd0);

      // Flush at edge 10..11 of a DIV: back to IDLE, no valid, result kept
      applyStimulus(F3_DIV, 32'hFFFFFFF9, 32'd2);
      repeat (10) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("flush busy", 32'(bus.busy), 32'd0);
      checkOutput("flush result kept", bus.result, 32'd14);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.result_valid) seen++;
      end
      checkOutput("flush no valid", 32'(seen), 32'd0);
      checkOutput("flush result still kept", bus.result, 32'd14);

      // flush together with start in IDLE drops the start
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.func3 = F3_MUL; bus.op_a = 32'd2; bus.op_b = 32'd2;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      checkOutput("flush+start busy", 32'(bus.busy), 32'd0);

      // flush in DONE: the pulse stands, result written by the special case stays
      applyStimulus(F3_DIVU, 32'd9, 32'd0);
      checkOutput("done flush valid", 32'(bus.result_valid), 32'd1);
      bus.flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b0;
      checkOutput("done flush state", {30'd0, bus.busy, bus.result_valid}, 32'd0);
      checkOutput("done flush result", bus.result, 32'hFFFFFFFF);

      // Reset at edge 20 of a MUL, then a fresh op completes normally
      applyStimulus(F3_MUL, 32'd7, 32'hFFFFFFFD);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mid reset outputs", {bus.result[29:0], bus.busy, bus.result_valid}, 32'd0);
      checkOutput("mid reset result", bus.result, 32'd0);
      rst = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.result_valid) seen++;
      end
      checkOutput("mid reset no valid", 32'(seen), 32'd0);
      applyStimulus(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      waitValid(0, res, lat, busyHeld);
      checkOutput("post reset result", res, 32'hFFFFFFFE);
      checkOutput("post reset latency", 32'(lat), 32'd33);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
